axis_s_fifo: RTL and testbench
==============================

Name: axis_s_fifo

Overview:
AXI-Stream slave (receiver) for the AXIS master in the same subsystem. It accepts beats into a DEPTH-entry show-ahead FIFO and exposes them to a local consumer through a simple valid/read-enable port. It also tracks packet boundaries from tlast and reports each packet's length and a running packet count.

Parameters:
DATA_W, 32, tdata / rd_data width
DEPTH, 8, FIFO entries; power of 2, >= 2
ADDR_W, 3, log2(DEPTH); pointer width

Ports:
aclk  in  1  clock
areset_n  in  1  reset, asynchronous, active-low
tvalid  in  1  AXIS beat valid from master
tready  out  1  AXIS ready to master
tdata  in  DATA_W  AXIS beat data
tlast  in  1  AXIS end-of-packet marker
rd_en  in  1  consumer pops the head entry
rd_valid  out  1  FIFO non-empty; rd_data/rd_last are valid
rd_data  out  DATA_W  head-entry data (show-ahead)
rd_last  out  1  head-entry tlast
level  out  ADDR_W+1  current occupancy, 0..DEPTH
pkt_done  out  1  one-cycle pulse, cycle after a tlast beat is accepted
pkt_len  out  16  beat count of the last completed packet
pkt_cnt  out  16  completed packets since reset; wraps 0xFFFF->0

Behaviour:
- Reset (async assert, sync to aclk edge on deassert): pointers=0, level=0, tready=0 while areset_n low, rd_valid=0, rd_data=0, rd_last=0, pkt_done=0, pkt_len=0, pkt_cnt=0, internal cur_len=0. Reset mid-packet discards all stored beats and the partial count.
- tready = areset_n & (level != DEPTH). Driven from registered state only; no combinational path from tvalid.
- Accept: tvalid & tready at a rising edge. {tlast,tdata} is written to mem[wptr] and wptr increments, wrapping at DEPTH.
- Pop: rd_en & rd_valid at a rising edge. rptr increments, wrapping. rd_en while rd_valid=0 is ignored with no state change.
- Show-ahead read: rd_data/rd_last = mem[rptr] whenever rd_valid=1; rd_data=0 and rd_last=0 when empty.
- Latency: a beat accepted at edge N gives rd_valid=1 with that data after edge N. The consumer can pop it at edge N+1.
- level: +1 on accept only, -1 on pop only, unchanged on simultaneous accept and pop.
- Full (level=DEPTH): tready=0. Simultaneous pop frees an entry; tready returns to 1 the following cycle.
- Empty with a simultaneous accept and rd_en: the write happens, the pop is ignored, level goes to 1.
- Packet tracking on each accepted beat:
  - tlast=0: cur_len <= cur_len+1, saturating at 0xFFFF.
  - tlast=1: pkt_len <= cur_len+1 (saturating); cur_len <= 0; pkt_cnt <= pkt_cnt+1; pkt_done=1 for the next cycle only.
- Back-to-back tlast beats produce consecutive pkt_done pulses, each with pkt_len=1.
- Packet stats follow acceptance, not consumer reads.
- tdata/tlast are don't-care while tvalid=0.
- The block does not check whether tvalid is held until handshake.

Test Plan:
- Reset, then a single beat 0xDEADBEEF with tlast=1 and rd_en=0 -> tready=1; next cycle rd_valid=1, rd_data=0xDEADBEEF, rd_last=1, level=1, pkt_done pulse, pkt_len=1, pkt_cnt=1.
- Stream 8 beats 0x1..0x8 with tlast on beat 8 and rd_en=0 -> level=8, tready=0 after the 8th accept, 9th beat held off. Then pop all 8 -> data 0x1..0x8 in order, rd_last only on 0x8, pkt_len=8.
- Full FIFO, tvalid=1 with rd_en=1 every cycle -> one accept per cycle after the first pop, level stays 7..8, no data lost or duplicated, sequence intact.
- Empty FIFO, tvalid=1 and rd_en=1 on the same edge with tdata=0xA5 -> level=1, rd_data=0xA5; the ignored pop leaves rptr unchanged.
- Two packets of lengths 3 and 1, back to back -> pkt_done pulses after beats 3 and 4; pkt_len=3 then 1; pkt_cnt=2.
- Assert areset_n low after 2 beats of a packet -> tready=0, level=0, rd_valid=0 immediately. After release, a new 2-beat packet reports pkt_len=2, pkt_cnt=1.

Source files
------------

// File: rtl/axis_s_fifo.sv
// AXI-Stream receiver: DEPTH-entry show-ahead FIFO with a valid/read-enable consumer port,
// plus per-packet length and running packet count derived from tlast on accepted beats.
module axis_s_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              aclk,
  input  logic              areset_n,
  // AXI-Stream slave side
  input  logic              tvalid_i,
  output logic              tready_o,
  input  logic [DATA_W-1:0] tdata_i,
  input  logic              tlast_i,
  // Local consumer side
  input  logic              rd_en_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o,
  output logic [ADDR_W:0]   level_o,
  // Packet statistics
  output logic              pkt_done_o,
  output logic [15:0]       pkt_len_o,
  output logic [15:0]       pkt_cnt_o
);

  localparam logic [ADDR_W:0] LevelFull = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LevelOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);

  // Each entry holds {tlast, tdata}
  logic [DATA_W:0]   mem_q [DEPTH];
  logic [DATA_W:0]   head;

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   level_q, level_d;

  logic [15:0]       cur_len_q, cur_len_d;
  logic [15:0]       pkt_len_q, pkt_len_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic              pkt_done_q, pkt_done_d;
  logic [15:0]       cur_inc;

  logic              accept;
  logic              pop;

  // Handshakes and show-ahead outputs, all derived from registered state
  always_comb begin
    rd_valid_o = (level_q != '0);
    // Gated by reset so the master sees not-ready for as long as reset is held
    tready_o   = areset_n & (level_q != LevelFull);
    accept     = tvalid_i & tready_o;
    // A read request against an empty FIFO is simply dropped
    pop        = rd_en_i & rd_valid_o;
    head       = mem_q[rptr_q];
    rd_data_o  = rd_valid_o ? head[DATA_W-1:0] : '0;
    rd_last_o  = rd_valid_o & head[DATA_W];
    level_o    = level_q;
    pkt_done_o = pkt_done_q;
    pkt_len_o  = pkt_len_q;
    pkt_cnt_o  = pkt_cnt_q;
  end

  // Next-state for pointers, occupancy and packet statistics
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    cur_len_d  = cur_len_q;
    pkt_len_d  = pkt_len_q;
    pkt_cnt_d  = pkt_cnt_q;
    pkt_done_d = 1'b0;
    cur_inc    = (cur_len_q == 16'hFFFF) ? 16'hFFFF : cur_len_q + 16'd1;

    // DEPTH is a power of two, so the pointers wrap naturally
    if (accept) begin
      wptr_d = wptr_q + PtrOne;
    end
    if (pop) begin
      rptr_d = rptr_q + PtrOne;
    end

    unique case ({accept, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase

    // Statistics follow acceptance, independent of what the consumer has read
    if (accept) begin
      if (tlast_i) begin
        pkt_len_d  = cur_inc;
        cur_len_d  = '0;
        pkt_cnt_d  = pkt_cnt_q + 16'd1;
        pkt_done_d = 1'b1;
      end else begin
        cur_len_d  = cur_inc;
      end
    end
  end

  // Control state; reset drops stored beats and any partial packet count
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      cur_len_q  <= '0;
      pkt_len_q  <= '0;
      pkt_cnt_q  <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      cur_len_q  <= cur_len_d;
      pkt_len_q  <= pkt_len_d;
      pkt_cnt_q  <= pkt_cnt_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  // Beat storage; contents need no reset since reads are gated by occupancy
  always_ff @(posedge aclk) begin
    if (accept) begin
      mem_q[wptr_q] <= {tlast_i, tdata_i};
    end
  end

endmodule

// File: tb/tb_axis_s_fifo.sv
// Self-checking bench for axis_s_fifo: scoreboard queue of accepted beats, a small packet
// statistics model, and directed scenarios for fill, full/pop overlap, empty overlap and reset.
module tb_axis_s_fifo;

  localparam int unsigned DataW = 32;
  localparam int unsigned Depth = 8;
  localparam int unsigned AddrW = 3;

  logic             aclk;
  logic             areset_n;
  logic             tvalid;
  logic             tready;
  logic [DataW-1:0] tdata;
  logic             tlast;
  logic             rd_en;
  logic             rd_valid;
  logic [DataW-1:0] rd_data;
  logic             rd_last;
  logic [AddrW:0]   level;
  logic             pkt_done;
  logic [15:0]      pkt_len;
  logic [15:0]      pkt_cnt;

  axis_s_fifo #(
    .DATA_W (DataW),
    .DEPTH  (Depth),
    .ADDR_W (AddrW)
  ) u_dut (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .tvalid_i   (tvalid),
    .tready_o   (tready),
    .tdata_i    (tdata),
    .tlast_i    (tlast),
    .rd_en_i    (rd_en),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .rd_last_o  (rd_last),
    .level_o    (level),
    .pkt_done_o (pkt_done),
    .pkt_len_o  (pkt_len),
    .pkt_cnt_o  (pkt_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Scoreboard of accepted {tlast, tdata}, in acceptance order
  logic [DataW:0] sb_q [$];

  // Packet statistics model
  logic [15:0] m_cur, m_len, m_cnt;
  logic        m_done;

  // Handshake outcome of the most recent cycle
  bit acc_flag;
  bit pop_flag;
  bit chk_band;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_cur  = '0;
    m_len  = '0;
    m_cnt  = '0;
    m_done = 1'b0;
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // One clock: check outputs at the falling edge, update models, return just after the
  // next rising edge so the caller can drive the following cycle's inputs.
  task automatic cycle();
    bit acc;
    bit pp;
    @(negedge aclk);
    acc = tvalid && areset_n && (sb_q.size() != Depth);
    pp  = rd_en && (sb_q.size() != 0);
    check("tready", 64'(tready), 64'(areset_n && (sb_q.size() != Depth)));
    check("level", 64'(level), 64'(sb_q.size()));
    check("rd_valid", 64'(rd_valid), 64'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      check("rd_data", 64'(rd_data), 64'(sb_q[0][DataW-1:0]));
      check("rd_last", 64'(rd_last), 64'(sb_q[0][DataW]));
    end else begin
      check("rd_data_empty", 64'(rd_data), 64'd0);
      check("rd_last_empty", 64'(rd_last), 64'd0);
    end
    check("pkt_done", 64'(pkt_done), 64'(m_done));
    check("pkt_len", 64'(pkt_len), 64'(m_len));
    check("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
    if (chk_band) begin
      check("level_band", 64'(level >= 7 && level <= 8), 64'd1);
    end
    if (pp) void'(sb_q.pop_front());
    if (acc) sb_q.push_back({tlast, tdata});
    m_done = acc && tlast;
    if (acc) begin
      if (tlast) begin
        m_len = sat_inc(m_cur);
        m_cur = '0;
        m_cnt = m_cnt + 16'd1;
      end else begin
        m_cur = sat_inc(m_cur);
      end
    end
    acc_flag = acc;
    pop_flag = pp;
    @(posedge aclk);
    #1;
  endtask

  // Offer n beats base, base+1, ...; tlast on the final one if last_end
  task automatic push_stream(input int n, input logic [31:0] base, input bit rd,
                             input bit last_end);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 200) begin
      tvalid = 1'b1;
      tdata  = base + 32'(sent);
      tlast  = last_end && (sent == n - 1);
      rd_en  = rd;
      cycle();
      if (acc_flag) sent++;
      guard++;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    rd_en  = 1'b0;
    check("stream_sent", 64'(sent), 64'(n));
  endtask

  task automatic drain();
    int guard = 0;
    rd_en = 1'b1;
    while (sb_q.size() != 0 && guard < 50) begin
      cycle();
      guard++;
    end
    rd_en = 1'b0;
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    areset_n = 1'b0;
    tvalid   = 1'b0;
    tdata    = '0;
    tlast    = 1'b0;
    rd_en    = 1'b0;
    chk_band = 1'b0;
    model_reset();
    cycle();
    cycle();
    areset_n = 1'b1;
    cycle();

    // Single beat with tlast
    tvalid = 1'b1;
    tdata  = 32'hDEADBEEF;
    tlast  = 1'b1;
    cycle();
    tvalid = 1'b0;
    tlast  = 1'b0;
    cycle();
    check("single_pkt_len", 64'(pkt_len), 64'd1);
    drain();

    // Fill to full, hold off a ninth beat, then pop everything in order
    push_stream(8, 32'h1, 1'b0, 1'b1);
    check("full_level", 64'(level), 64'd8);
    tvalid = 1'b1;
    tdata  = 32'h9;
    cycle();
    cycle();
    check("ninth_held", 64'(acc_flag), 64'd0);
    tvalid = 1'b0;
    drain();
    check("fill_pkt_len", 64'(pkt_len), 64'd8);

    // Full with continuous offer and read: one accept per cycle, level within 7..8
    push_stream(8, 32'h100, 1'b0, 1'b0);
    chk_band = 1'b1;
    push_stream(20, 32'h200, 1'b1, 1'b1);
    chk_band = 1'b0;
    drain();

    // Empty FIFO: write and read request on the same edge
    tvalid = 1'b1;
    tdata  = 32'hA5;
    tlast  = 1'b1;
    rd_en  = 1'b1;
    cycle();
    tvalid = 1'b0;
    tlast  = 1'b0;
    rd_en  = 1'b0;
    check("empty_ovl_pop_ignored", 64'(pop_flag), 64'd0);
    cycle();
    check("empty_ovl_level", 64'(level), 64'd1);
    check("empty_ovl_data", 64'(rd_data), 64'hA5);
    drain();

    // Back-to-back packets of length 3 and 1
    push_stream(3, 32'h300, 1'b0, 1'b1);
    push_stream(1, 32'h400, 1'b0, 1'b1);
    cycle();
    check("b2b_len_last", 64'(pkt_len), 64'd1);
    drain();

    // Reset partway through a packet
    push_stream(2, 32'h500, 1'b0, 1'b0);
    areset_n = 1'b0;
    #1;
    check("rst_tready", 64'(tready), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    model_reset();
    cycle();
    cycle();
    areset_n = 1'b1;
    cycle();
    push_stream(2, 32'h600, 1'b0, 1'b1);
    cycle();
    check("post_rst_len", 64'(pkt_len), 64'd2);
    check("post_rst_cnt", 64'(pkt_cnt), 64'd1);
    drain();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Absolute time bound in case a scenario stalls
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
